// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: two-digit BCD to binary converter using reverse double-dabble,
// one shift per clock with a start/busy/done handshake.
// Optional build macro BCD_DIGIT_CHECK_EN: flags non-BCD digits at load, skips the
// shift phase and reports bin=0, err=1 one cycle after start.
module bcd_to_binary_seq #(
    parameter int NDIGITS = 2,
    parameter int BIN_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       d_tens_i,
    input  logic [3:0]       d_ones_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BIN_W-1:0] bin_o,
    output logic             err_o
);
    localparam int BCD_W = 4 * NDIGITS;
    localparam int CW    = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic               load;
    logic               err_flag;

    assign load = (state_q == IDLE) && start_i;

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q;
    // Digit legality is captured at load and cleared by the next accepted start
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (load)
            err_q <= (d_tens_i > 4'd9) || (d_ones_i > 4'd9);
    end
    assign err_flag = err_q;
`else
    assign err_flag = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: a flagged illegal input bypasses the shift phase
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start_i ? SHIFT : IDLE;
            SHIFT:   state_d = (err_flag || cnt_q == LAST) ? DONE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: busy spans SHIFT and the DONE cycle; bin is the accumulated result
    always_comb begin
        busy_o = state_q != IDLE;
        done_o = state_q == DONE;
        bin_o  = bin_q;
        err_o  = err_flag;
    end

    // Datapath registers: latched digits, partial binary result, iteration count
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
        end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            cnt_q <= cnt_d;
        end
    end

    // One reverse double-dabble step: shift right, then pull each digit >= 8 down by 3
    always_comb begin
        shifted = {bcd_q, bin_q} >> 1;
        for (int i = 0; i < NDIGITS; i++)
            if (shifted[BIN_W+4*i +: 4] >= 4'd8)
                shifted[BIN_W+4*i +: 4] = shifted[BIN_W+4*i +: 4] - 4'd3;
        bcd_d = bcd_q;
        bin_d = bin_q;
        cnt_d = cnt_q;
        if (load) begin
            bcd_d = BCD_W'({d_tens_i, d_ones_i});
            bin_d = '0;
            cnt_d = '0;
        end else if (state_q == SHIFT && !err_flag) begin
            {bcd_d, bin_d} = shifted;
            cnt_d = cnt_q + CW'(1);
        end
    end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: scoreboard bench for bcd_to_binary_seq using directed vectors.
module tb_bcd_to_binary_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [3:0] d_tens = 4'd0;
    logic [3:0] d_ones = 4'd0;
    logic       busy, done, err;
    logic [6:0] bin;

    typedef struct {
        int val;
        int err;
        int issue;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_to_binary_seq #(.NDIGITS(2), .BIN_W(7)) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .d_tens_i(d_tens),
        .d_ones_i(d_ones),
        .busy_o(busy),
        .done_o(done),
        .bin_o(bin),
        .err_o(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("bin", int'(bin), mon_e.val);
                check("err", int'(err), mon_e.err);
                check("latency", cyc - mon_e.issue, mon_e.lat);
                check("busy_at_done", int'(busy), 1);
            end
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic convert(input logic [3:0] t, input logic [3:0] o, input int val,
                           input int e, input int lat);
        int n;
        @(negedge clk);
        d_tens  = t;
        d_ones  = o;
        start_i = 1'b1;
        sb.push_back('{val, e, cyc, lat});
        @(negedge clk);
        start_i = 1'b0;
        d_tens  = 4'd8;
        d_ones  = 4'd1;
        wait_idle(n);
        check("busy_cycles", n, lat);
        repeat (3) @(negedge clk);
        check("bin_hold", int'(bin), val);
        check("err_hold", int'(err), e);
    endtask

    initial begin
        int n;
        int c;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bin", int'(bin), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_bin", int'(bin), 0);

        convert(4'd2, 4'd2, 22, 0, 8);
        convert(4'd0, 4'd8, 8, 0, 8);
        convert(4'd1, 4'd6, 16, 0, 8);
        convert(4'd1, 4'd8, 18, 0, 8);
        convert(4'd1, 4'd5, 15, 0, 8);
        convert(4'd3, 4'd0, 30, 0, 8);
        convert(4'd0, 4'd0, 0, 0, 8);
        convert(4'd9, 4'd9, 99, 0, 8);

        // Starts during a conversion are ignored; changed digits must not leak in
        @(negedge clk);
        d_tens  = 4'd9;
        d_ones  = 4'd9;
        start_i = 1'b1;
        sb.push_back('{99, 0, cyc, 8});
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        d_tens  = 4'd1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle(n);
        repeat (2) @(negedge clk);
        check("ignored_bin", int'(bin), 99);

        // Held start: second conversion accepted on first IDLE edge after DONE
        @(negedge clk);
        d_tens  = 4'd4;
        d_ones  = 4'd2;
        start_i = 1'b1;
        c = cyc;
        sb.push_back('{42, 0, c, 8});
        sb.push_back('{42, 0, c + 9, 8});
        repeat (10) @(negedge clk);
        start_i = 1'b0;
        wait_idle(n);
        repeat (2) @(negedge clk);
        check("held_bin", int'(bin), 42);

        // Reset mid-conversion aborts with no done pulse
        @(negedge clk);
        d_tens  = 4'd3;
        d_ones  = 4'd0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_bin", int'(bin), 0);
        check("abort_err", int'(err), 0);
        convert(4'd1, 4'd5, 15, 0, 8);

        // Reset and start together: reset wins
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        check("rst_start_busy", int'(busy), 0);
        @(negedge clk);
        check("rst_start_idle", int'(busy), 0);

`ifdef BCD_DIGIT_CHECK_EN
        convert(4'hA, 4'd3, 0, 1, 2);
        convert(4'd0, 4'd7, 7, 0, 8);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
